// File: rtl/link_token_node.sv
// link_token_node: token-ring forwarding stage; buffers upstream token beats,
// holds tokens addressed to this node for HOLD_CYCLES then stamps them, and
// forwards all other tokens unchanged to the downstream anchor.
// Ports:
//   i_clk, i_rstn                  clock, synchronous active-low reset
//   i_wen, i_token, i_clk_cnt, i_id    upstream token beat (no backpressure)
//   o_wen, o_token, o_clk_cnt, o_id    downstream token beat, one-cycle pulse
//   o_busy                         FSM not IDLE or FIFO non-empty
//   o_overflow                     sticky, a beat was dropped on a full FIFO
// Optional macro LINK_TOKEN_NODE_STATS_EN adds o_own_cnt, o_pass_cnt,
// o_drop_cnt (16-bit saturating counters).
module link_token_node #(
   parameter int ID          = 0,
   parameter int HOLD_CYCLES = 4,
   parameter int FIFO_DEPTH  = 2
) (
   input  logic        i_clk,
   input  logic        i_rstn,
   input  logic        i_wen,
   input  logic [31:0] i_token,
   input  logic [31:0] i_clk_cnt,
   input  logic [31:0] i_id,
   output logic        o_wen,
   output logic [31:0] o_token,
   output logic [31:0] o_clk_cnt,
   output logic [31:0] o_id,
   output logic        o_busy,
`ifdef LINK_TOKEN_NODE_STATS_EN
   output logic [15:0] o_own_cnt,
   output logic [15:0] o_pass_cnt,
   output logic [15:0] o_drop_cnt,
`endif
   output logic        o_overflow
);
   localparam int AW = $clog2(FIFO_DEPTH);
   typedef struct packed {
      logic [31:0] token;
      logic [31:0] clk_cnt;
      logic [31:0] id;
   } beat_t;
   typedef enum logic [1:0] {IDLE, HOLD, SEND} state_t;
   state_t        state_q, state_d;
   beat_t         mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0]   fcnt_q;
   beat_t         work_q, work_d, head;
   logic          own_q, own_d;
   logic [7:0]    hold_q, hold_d;
   logic          wen_q, wen_d;
   logic [31:0]   token_q, token_d, clk_q, clk_d, id_q, id_d;
   logic          ovf_q;
   logic          empty, full, pop, push, drop, head_own;
   assign empty    = fcnt_q == '0;
   assign full     = fcnt_q == (AW+1)'(FIFO_DEPTH);
   assign head     = mem_q[rd_q];
   assign head_own = head.id == 32'(ID);
   assign pop      = state_q == IDLE && !empty;
   // a full FIFO still accepts a beat when the head leaves in the same cycle
   assign push     = i_wen && (!full || pop);
   assign drop     = i_wen && full && !pop;
   always_ff @(posedge i_clk)
      if (push) mem_q[wr_q] <= beat_t'{i_token, i_clk_cnt, i_id};
   always_ff @(posedge i_clk)
      if (!i_rstn) begin
         wr_q   <= '0;
         rd_q   <= '0;
         fcnt_q <= '0;
      end else begin
         if (push) wr_q <= wr_q + AW'(1);
         if (pop) rd_q <= rd_q + AW'(1);
         fcnt_q <= fcnt_q + (AW+1)'(push) - (AW+1)'(pop);
      end
   always_ff @(posedge i_clk)
      if (!i_rstn) state_q <= IDLE;
      else state_q <= state_d;
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (!empty) state_d = (head_own && HOLD_CYCLES != 0) ? HOLD : SEND;
         HOLD:    if (hold_q <= 8'd1) state_d = SEND;
         SEND:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_comb begin
      work_d  = pop ? head : work_q;
      own_d   = pop ? head_own : own_q;
      hold_d  = (pop && head_own) ? 8'(HOLD_CYCLES) : (state_q == HOLD) ? hold_q - 8'd1 : hold_q;
      wen_d   = state_q == SEND;
      // owned tokens are stamped on the way out; foreign ones pass untouched
      token_d = wen_d ? (own_q ? work_q.token + 32'd1 : work_q.token) : token_q;
      clk_d   = wen_d ? (own_q ? work_q.clk_cnt + 32'(HOLD_CYCLES) : work_q.clk_cnt) : clk_q;
      id_d    = wen_d ? (own_q ? 32'(ID) + 32'd1 : work_q.id) : id_q;
   end
   always_ff @(posedge i_clk)
      if (!i_rstn) begin
         work_q  <= '0;
         own_q   <= 1'b0;
         hold_q  <= '0;
         wen_q   <= 1'b0;
         token_q <= '0;
         clk_q   <= '0;
         id_q    <= '0;
         ovf_q   <= 1'b0;
      end else begin
         work_q  <= work_d;
         own_q   <= own_d;
         hold_q  <= hold_d;
         wen_q   <= wen_d;
         token_q <= token_d;
         clk_q   <= clk_d;
         id_q    <= id_d;
         ovf_q   <= ovf_q | drop;
      end
   assign o_wen      = wen_q;
   assign o_token    = token_q;
   assign o_clk_cnt  = clk_q;
   assign o_id       = id_q;
   assign o_busy     = state_q != IDLE || !empty;
   assign o_overflow = ovf_q;
`ifdef LINK_TOKEN_NODE_STATS_EN
   logic [15:0] own_cnt_q, pass_cnt_q, drop_cnt_q;
   always_ff @(posedge i_clk)
      if (!i_rstn) begin
         own_cnt_q  <= '0;
         pass_cnt_q <= '0;
         drop_cnt_q <= '0;
      end else begin
         if (wen_d && own_q && ~&own_cnt_q) own_cnt_q <= own_cnt_q + 16'd1;
         if (wen_d && !own_q && ~&pass_cnt_q) pass_cnt_q <= pass_cnt_q + 16'd1;
         if (drop && ~&drop_cnt_q) drop_cnt_q <= drop_cnt_q + 16'd1;
      end
   assign o_own_cnt  = own_cnt_q;
   assign o_pass_cnt = pass_cnt_q;
   assign o_drop_cnt = drop_cnt_q;
`endif
endmodule

// File: tb/tb_link_token_node.sv
// tb_link_token_node: self-checking bench for link_token_node (ID=3,
// HOLD_CYCLES=4, FIFO_DEPTH=2); vector table plus multi-cycle sequences,
// output beats checked against a scoreboard of expected beats and cycles.
module tb_link_token_node;
   localparam int ID = 3;
   localparam int H  = 4;
   logic        i_clk = 1'b0, i_rstn = 1'b0, i_wen = 1'b0;
   logic [31:0] i_token = '0, i_clk_cnt = '0, i_id = '0;
   logic        o_wen, o_busy, o_overflow;
   logic [31:0] o_token, o_clk_cnt, o_id;
`ifdef LINK_TOKEN_NODE_STATS_EN
   logic [15:0] o_own_cnt, o_pass_cnt, o_drop_cnt;
`endif
   int checks = 0, failures = 0, cyc = 0;
   typedef struct {
      logic [31:0] token, clk_cnt, id;
      int          at;
   } exp_t;
   typedef struct {
      logic [31:0] token, clk_cnt, id, e_token, e_clk, e_id;
      int          lat;
   } vec_t;
   exp_t sb[$];
   exp_t mon_e;
   link_token_node #(.ID(ID), .HOLD_CYCLES(H), .FIFO_DEPTH(2)) dut (
      .i_clk(i_clk),
      .i_rstn(i_rstn),
      .i_wen(i_wen),
      .i_token(i_token),
      .i_clk_cnt(i_clk_cnt),
      .i_id(i_id),
      .o_wen(o_wen),
      .o_token(o_token),
      .o_clk_cnt(o_clk_cnt),
      .o_id(o_id),
      .o_busy(o_busy),
`ifdef LINK_TOKEN_NODE_STATS_EN
      .o_own_cnt(o_own_cnt),
      .o_pass_cnt(o_pass_cnt),
      .o_drop_cnt(o_drop_cnt),
`endif
      .o_overflow(o_overflow)
   );
   always #5 i_clk = ~i_clk;
   always @(posedge i_clk) cyc <= cyc + 1;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
      end
   endtask
   task automatic step();
      @(posedge i_clk);
      #1;
   endtask
   task automatic beat(input logic [31:0] t, input logic [31:0] c, input logic [31:0] d);
      i_wen = 1'b1;
      i_token = t;
      i_clk_cnt = c;
      i_id = d;
      step();
      i_wen = 1'b0;
   endtask
   task automatic expect_out(input logic [31:0] t, input logic [31:0] c, input logic [31:0] d, input int at);
      exp_t e;
      e.token = t;
      e.clk_cnt = c;
      e.id = d;
      e.at = at;
      sb.push_back(e);
   endtask
   // every o_wen pulse must match the oldest outstanding expectation
   always @(negedge i_clk)
      if (o_wen) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL spurious_wen cycle=%0d got=1 expected=0", cyc);
         end else begin
            mon_e = sb.pop_front();
            chk("wen_cycle", cyc, mon_e.at);
            chk("o_token", o_token, mon_e.token);
            chk("o_clk_cnt", o_clk_cnt, mon_e.clk_cnt);
            chk("o_id", o_id, mon_e.id);
         end
      end
   initial begin
      vec_t v[6];
      int   s;
      v[0] = '{32'h10, 32'h100, 32'd5, 32'h10, 32'h100, 32'd5, 3};
      v[1] = '{32'h10, 32'h100, 32'd3, 32'h11, 32'h104, 32'd4, 3 + H};
      v[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd3, 32'h0, 32'h2, 32'd4, 3 + H};
      v[3] = '{32'h1234_5678, 32'hABCD, 32'd2, 32'h1234_5678, 32'hABCD, 32'd2, 3};
      v[4] = '{32'hDEAD_BEEF, 32'h0, 32'h8000_0003, 32'hDEAD_BEEF, 32'h0, 32'h8000_0003, 3};
      v[5] = '{32'h0, 32'hFFFF_FFFC, 32'd3, 32'h1, 32'h0, 32'd4, 3 + H};
      // reset with i_wen held high: the beat must be ignored
      i_rstn = 1'b0;
      i_wen = 1'b1;
      i_token = '1;
      i_id = 32'd3;
      repeat (3) step();
      @(negedge i_clk);
      chk("rst_wen", o_wen, 0);
      chk("rst_token", o_token, 0);
      chk("rst_clk_cnt", o_clk_cnt, 0);
      chk("rst_id", o_id, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_overflow", o_overflow, 0);
      step();
      i_rstn = 1'b1;
      i_wen = 1'b0;
      step();
      step();
      @(negedge i_clk);
      chk("post_rst_busy", o_busy, 0);
      step();
      foreach (v[i]) begin
         s = cyc;
         expect_out(v[i].e_token, v[i].e_clk, v[i].e_id, s + v[i].lat);
         beat(v[i].token, v[i].clk_cnt, v[i].id);
         repeat (v[i].lat) step();
         @(negedge i_clk);
         chk("vec_busy_after", o_busy, 0);
         chk("vec_hold_token", o_token, v[i].e_token);
         step();
      end
      // overflow: owned A, then B, C fill the FIFO, D is dropped
      s = cyc;
      expect_out(32'h21, 32'h204, 32'd4, s + 7);
      expect_out(32'hB, 32'hB0, 32'd7, s + 9);
      expect_out(32'hC, 32'hC0, 32'd8, s + 11);
      beat(32'h20, 32'h200, 32'd3);
      beat(32'hB, 32'hB0, 32'd7);
      beat(32'hC, 32'hC0, 32'd8);
      @(negedge i_clk);
      chk("ovf_before", o_overflow, 0);
      beat(32'hD, 32'hD0, 32'd9);
      @(negedge i_clk);
      chk("ovf_set", o_overflow, 1);
      chk("ovf_busy", o_busy, 1);
      repeat (8) step();
      @(negedge i_clk);
      chk("ovf_drained_busy", o_busy, 0);
      chk("ovf_sticky", o_overflow, 1);
      step();
      // reset in the middle of HOLD discards the owned token
      s = cyc;
      beat(32'h30, 32'h300, 32'd3);
      step();
      step();
      i_rstn = 1'b0;
      step();
      @(negedge i_clk);
      chk("mid_rst_wen", o_wen, 0);
      chk("mid_rst_token", o_token, 0);
      chk("mid_rst_clk_cnt", o_clk_cnt, 0);
      chk("mid_rst_id", o_id, 0);
      chk("mid_rst_busy", o_busy, 0);
      chk("mid_rst_overflow", o_overflow, 0);
      i_rstn = 1'b1;
      repeat (10) step();
      @(negedge i_clk);
      chk("mid_rst_idle", o_busy, 0);
      step();
`ifdef LINK_TOKEN_NODE_STATS_EN
      s = cyc;
      expect_out(32'h41, 32'h404, 32'd4, s + 7);
      expect_out(32'h50, 32'h500, 32'd1, s + 9);
      expect_out(32'h60, 32'h600, 32'd2, s + 11);
      beat(32'h40, 32'h400, 32'd3);
      beat(32'h50, 32'h500, 32'd1);
      beat(32'h60, 32'h600, 32'd2);
      beat(32'h70, 32'h700, 32'd1);
      repeat (9) step();
      s = cyc;
      expect_out(32'h81, 32'h804, 32'd4, s + 7);
      beat(32'h80, 32'h800, 32'd3);
      repeat (7) step();
      s = cyc;
      expect_out(32'h90, 32'h900, 32'd6, s + 3);
      beat(32'h90, 32'h900, 32'd6);
      repeat (4) step();
      @(negedge i_clk);
      chk("stat_own", 32'(o_own_cnt), 2);
      chk("stat_pass", 32'(o_pass_cnt), 3);
      chk("stat_drop", 32'(o_drop_cnt), 1);
      step();
`endif
      chk("scoreboard_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
